// File: rtl/rom_triangle_if.sv
// Row-fetch bus for the triangle pattern ROM.
// The consumer drives a row index; the ROM returns the registered pixel row.
interface rom_triangle_if;
    logic [7:0]   addr;
    logic [207:0] data;

    modport master (
        output addr,
        input  data
    );

    modport slave (
        input  addr,
        output data
    );
endinterface

// File: rtl/rom_triangle.sv
// Read-only 256 x 208 bitmap of an upright isosceles triangle.
// Rows are computed arithmetically from the index and registered once.
module rom_triangle (
    input  logic           clk,
    input  logic           rst_n,
    rom_triangle_if.slave  bus
);

    logic [11:0]  prod;
    logic [6:0]   w;
    logic [7:0]   lo;
    logic [7:0]   hi;
    logic [207:0] row;

    // Half-width from the index, then the inclusive column span it covers.
    always_comb begin
        prod = 12'(bus.addr) * 12'd13;
        w    = prod[11:5];
        lo   = 8'd103 - {1'b0, w};
        hi   = 8'd104 + {1'b0, w};
    end

    // Expand the span into a pixel mask; bit 0 is the leftmost column.
    always_comb begin
        row = '0;
        for (int c = 0; c < 208; c++) begin
            row[c] = (8'(c) >= lo) && (8'(c) <= hi);
        end
    end

    // Output register; reset forces the all-zero pattern, which no row uses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data <= '0;
        end else begin
            bus.data <= row;
        end
    end

endmodule

// File: tb/tb_rom_triangle.sv
// Directed bench for rom_triangle: reset, extremes, mid rows,
// back-to-back latency, full sweep with row properties, async reset.
module tb_rom_triangle;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rom_triangle_if bus ();

    rom_triangle dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [207:0] obs,
                       input logic [207:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic int half_w(input int r);
        return (r * 13) / 32;
    endfunction

    function automatic logic [207:0] ref_row(input int r);
        int w;
        logic [207:0] m;
        w = half_w(r);
        m = '1;
        m = m >> (208 - (2 * w + 2));
        return m << (103 - w);
    endfunction

    function automatic int rises(input logic [207:0] d);
        int n;
        n = d[0] ? 1 : 0;
        for (int c = 1; c < 208; c++)
            if (d[c] && !d[c-1]) n++;
        return n;
    endfunction

    function automatic logic [207:0] mirror(input logic [207:0] d);
        logic [207:0] m;
        for (int c = 0; c < 208; c++) m[c] = d[207 - c];
        return m;
    endfunction

    function automatic logic [207:0] span(input int lo, input int hi);
        logic [207:0] m;
        m = '0;
        for (int c = lo; c <= hi; c++) m[c] = 1'b1;
        return m;
    endfunction

    task automatic check_row(input string tag, input int r);
        logic [207:0] d;
        d = bus.data;
        chk(tag, d, ref_row(r));
        chk({tag, "_sym"}, d, mirror(d));
        chk({tag, "_contig"}, 208'(rises(d)), 208'(1));
        chk({tag, "_pop"}, 208'($countones(d)), 208'(2 * half_w(r) + 2));
    endtask

    logic [207:0] row0, row123, row69, row255;
    int prev_pop;
    int pop;

    initial begin
        checks   = 0;
        failures = 0;
        row0   = span(103, 104);
        row123 = span(54, 153);
        row69  = span(75, 132);
        row255 = '1;

        rst_n    = 1'b0;
        bus.addr = 8'd200;
        repeat (3) @(negedge clk);
        chk("reset_hold", bus.data, '0);

        bus.addr = 8'd0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("release_row0", bus.data, row0);
        chk("release_pop", 208'($countones(bus.data)), 208'(2));

        bus.addr = 8'd255;
        @(negedge clk);
        chk("row255", bus.data, row255);

        bus.addr = 8'd123;
        @(negedge clk);
        chk("row123", bus.data, row123);
        chk("row123_pop", 208'($countones(bus.data)), 208'(100));

        bus.addr = 8'd69;
        @(negedge clk);
        chk("row69", bus.data, row69);
        chk("row69_pop", 208'($countones(bus.data)), 208'(58));

        bus.addr = 8'd0;
        @(posedge clk);
        #1 bus.addr = 8'd123;
        chk("pipe0", bus.data, row0);
        @(posedge clk);
        #1 bus.addr = 8'd69;
        chk("pipe123", bus.data, row123);
        @(posedge clk);
        #1 bus.addr = 8'd255;
        chk("pipe69", bus.data, row69);
        @(posedge clk);
        #1 chk("pipe255", bus.data, row255);

        prev_pop = 0;
        for (int r = 0; r < 256; r++) begin
            @(negedge clk);
            bus.addr = 8'(r);
            @(negedge clk);
            check_row($sformatf("sweep%0d", r), r);
            pop = $countones(bus.data);
            chk($sformatf("mono%0d", r), 208'(pop >= prev_pop), 208'(1));
            prev_pop = pop;
        end

        @(negedge clk);
        bus.addr = 8'd100;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("async_clear", bus.data, '0);
        @(negedge clk);
        bus.addr = 8'd101;
        @(negedge clk);
        chk("reset_no_stale", bus.data, '0);
        rst_n = 1'b1;
        @(negedge clk);
        check_row("resume101", 101);
        for (int r = 102; r < 110; r++) begin
            bus.addr = 8'(r);
            @(negedge clk);
            check_row($sformatf("resume%0d", r), r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
